// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, 16x oversampled start/data/stop FSM.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int unsigned SW = 4;
    localparam int unsigned NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state, state_next;
    logic               rx_meta, rx_s;
    logic [SW-1:0]      s, s_next;
    logic [NW-1:0]      n, n_next;
    logic [NB_DATA-1:0] shreg, shreg_next;
    logic [NB_DATA-1:0] data_next;
    logic               done_next;
    logic               ferr_next;

`ifdef UART_RX_PARITY_EN
    logic parity_bit, parity_bit_next;
    logic perr_q, perr_next;
`endif

    // Synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_s        <= rx_meta;
            state       <= state_next;
            s           <= s_next;
            n           <= n_next;
            shreg       <= shreg_next;
            o_data      <= data_next;
            o_rx_done   <= done_next;
            o_frame_err <= ferr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            parity_bit <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            parity_bit <= parity_bit_next;
            perr_q     <= perr_next;
        end
    end

    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    // Next-state logic; counters move only on tick cycles, except the IDLE->START edge.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shreg_next = shreg;
        data_next  = o_data;
        done_next  = 1'b0;
        ferr_next  = o_frame_err;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit;
        perr_next       = perr_q;
`endif

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (s == S_LAST) begin
                        shreg_next = {rx_s, shreg[NB_DATA-1:1]};
                        s_next     = '0;
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (s == S_LAST) begin
                        parity_bit_next = rx_s;
                        s_next          = '0;
                        state_next      = STOP;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (i_tick) begin
                    if (s == S_STOP) begin
                        state_next = IDLE;
                        data_next  = shreg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = (^shreg) ^ parity_bit;
`endif
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expectations, a monitor checks each done pulse.
module tb_uart_rx;

    localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 168;
`else
    localparam int FRAME_TICKS = 152;
`endif

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_parity_err;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_done = 1'b0;

    uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Tick strobe every 10 clocks, changed away from the active edge.
    initial begin
        int cnt = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            cnt    = (cnt == 9) ? 0 : cnt + 1;
            i_tick = (cnt == 9);
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!i_reset && o_rx_done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("done_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("rx_data", 32'(o_data), 32'(e.d));
                check("frame_err", 32'(o_frame_err), 32'(e.fe));
                check("parity_err", 32'(o_parity_err), 32'(e.pe));
            end
        end
        prev_done = o_rx_done;
    end

    task automatic line(input logic v, input int clocks);
        i_rx = v;
        repeat (clocks) @(negedge clk);
    endtask

    // One frame; a bad stop is driven low long enough to be sampled, then released.
    task automatic send(input logic [7:0] d, input logic stop_ok, input logic pbit);
        exp_t e;
        e.d  = d;
        e.fe = ~stop_ok;
`ifdef UART_RX_PARITY_EN
        e.pe = (^d) ^ pbit;
`else
        e.pe = 1'b0;
`endif
        q.push_back(e);
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        line(pbit, BIT_CLKS);
`endif
        if (stop_ok) line(1'b1, BIT_CLKS);
        else begin
            line(1'b0, 110);
            line(1'b1, BIT_CLKS - 110);
        end
    endtask

    initial begin
        logic [7:0] d;
        exp_t       e;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", 32'(o_data), 32'h0);
        check("reset_done", 32'(o_rx_done), 32'h0);
        check("reset_ferr", 32'(o_frame_err), 32'h0);
        check("reset_perr", 32'(o_parity_err), 32'h0);
        i_reset = 1'b0;
        line(1'b1, 50);

        send(8'h55, 1'b1, 1'b0);
        line(1'b1, 300);
        check("hold_data_55", 32'(o_data), 32'h55);

        // Back-to-back, no idle gap.
        send(8'hA3, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        line(1'b1, 300);

        // Short low glitch must be rejected.
        line(1'b0, 30);
        line(1'b1, 400);
        check("glitch_data_hold", 32'(o_data), 32'h0F);
        check("glitch_ferr", 32'(o_frame_err), 32'h0);

        send(8'hFF, 1'b0, 1'b0);
        line(1'b1, 320);
        check("ferr_hold", 32'(o_frame_err), 32'h1);
        send(8'h12, 1'b1, 1'b0);
        line(1'b1, 300);
        check("ferr_cleared", 32'(o_frame_err), 32'h0);

        // Reset in the middle of data bit 4.
        d = 8'hB6;
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) line(d[i], BIT_CLKS);
        line(d[4], 80);
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        line(1'b1, 400);
        check("abort_data_zero", 32'(o_data), 32'h0);
        check("abort_ferr_zero", 32'(o_frame_err), 32'h0);
        send(8'h3C, 1'b1, 1'b0);
        line(1'b1, 300);
        check("after_abort_data", 32'(o_data), 32'h3C);

        // Break: line low for two full frames; the third start falls on a high line.
        e.d = 8'h00; e.fe = 1'b1; e.pe = 1'b0;
        q.push_back(e);
        q.push_back(e);
        line(1'b0, 2 * FRAME_TICKS * 10 + 40);
        line(1'b1, 400);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        line(1'b1, 300);
        check("parity_ok", 32'(o_parity_err), 32'h0);
        send(8'h07, 1'b1, 1'b0);
        line(1'b1, 300);
        check("parity_bad", 32'(o_parity_err), 32'h1);
`endif

        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
        check("all_frames_received", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
